// File: rtl/i2c_pkg.sv
// i2c_pkg: shared byte-word layout, FSM state encoding and word builder for the I2C transaction sequencer
package i2c_pkg;
  localparam int START_BIT = 15;
  localparam int STOP_BIT  = 14;
  localparam int ACK_BIT   = 8;
  localparam logic [7:0] READ_FILL = 8'hFF;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ARM, S_WAIT, S_RESULT, S_DONE} state_t;
  function automatic logic [15:0] build_word(input logic start, input logic stop, input logic ack, input logic [7:0] data);
    logic [15:0] w;
    w = '0;
    w[START_BIT] = start;
    w[STOP_BIT]  = stop;
    w[ACK_BIT]   = ack;
    w[7:0]       = data;
    return w;
  endfunction
endpackage

// File: rtl/i2c_byte_word_gen.sv
// i2c_byte_word_gen: maps a frame index plus latched command fields to the engine control word
// Ports: idx (frame index), rd/dev/reg_addr/len/wr_data (latched command, len already clamped),
//        word (16-bit control word), is_last (final frame), is_rd_data (frame returns a data byte)
module i2c_byte_word_gen
  import i2c_pkg::*;
#(
  parameter int MAX_LEN = 4,
  parameter int LEN_W   = 3,
  parameter int IDX_W   = LEN_W + 1
) (
  input  logic [IDX_W-1:0]     idx,
  input  logic                 rd,
  input  logic [6:0]           dev,
  input  logic [7:0]           reg_addr,
  input  logic [LEN_W-1:0]     len,
  input  logic [8*MAX_LEN-1:0] wr_data,
  output logic [15:0]          word,
  output logic                 is_last,
  output logic                 is_rd_data
);
  logic [IDX_W-1:0] last_idx;
  logic [IDX_W-1:0] widx;
  logic [7:0]       wbyte;
  // write: addr, reg, len data bytes; read: addr, reg, re-addr, len data bytes
  assign last_idx   = IDX_W'(len) + (rd ? IDX_W'(2) : IDX_W'(1));
  assign widx       = idx - IDX_W'(2);
  assign wbyte      = 8'(wr_data >> {widx, 3'b000});
  assign is_last    = idx == last_idx;
  assign is_rd_data = rd && idx >= IDX_W'(3);
  // read data frames ACK every byte but the last, which NACKs and stops
  assign word = idx == '0         ? build_word(1'b1, is_last, 1'b1, {dev, 1'b0}) :
                idx == IDX_W'(1)  ? build_word(1'b0, is_last, 1'b1, reg_addr) :
                rd && idx == IDX_W'(2) ? build_word(1'b1, 1'b0, 1'b1, {dev, 1'b1}) :
                rd                ? build_word(1'b0, is_last, is_last, READ_FILL) :
                                    build_word(1'b0, is_last, 1'b1, wbyte);
endmodule

// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: splits one register-level I2C transaction into byte frames for the byte engine
// Ports: cmd_* (host request), rd_valid/rd_data (received bytes), done/err_nack/err_timeout (completion),
//        byte_strobe/byte_word (frame issue), byte_read/byte_busy (engine result and activity)
// Optional: define I2C_TIMEOUT_EN to bound each frame to TIMEOUT_CYCLES clocks.
module i2c_txn_sequencer
  import i2c_pkg::*;
#(
  parameter int MAX_LEN        = 4,
  parameter int LEN_W          = 3,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_rd,
  input  logic [6:0]           cmd_dev_addr,
  input  logic [7:0]           cmd_reg_addr,
  input  logic [LEN_W-1:0]     cmd_len,
  input  logic [8*MAX_LEN-1:0] cmd_wr_data,
  output logic                 rd_valid,
  output logic [7:0]           rd_data,
  output logic                 done,
  output logic                 err_nack,
  output logic                 err_timeout,
  output logic                 byte_strobe,
  output logic [15:0]          byte_word,
  input  logic [8:0]           byte_read,
  input  logic                 byte_busy
);
  localparam int IDX_W = LEN_W + 1;
  state_t state_q, state_d;
  logic rd_q, rd_d, nack_q, nack_d, rd_valid_q, rd_valid_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] reg_q, reg_d, rd_data_q, rd_data_d;
  logic [LEN_W-1:0] len_q, len_d, len_c;
  logic [8*MAX_LEN-1:0] wdata_q, wdata_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0] word_q, word_d, gen_word;
  logic accept, is_last, is_rd_data, tmo;
  assign accept = cmd_valid && cmd_ready;
  assign len_c  = cmd_len > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : cmd_len;
  i2c_byte_word_gen #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .IDX_W(IDX_W)) u_gen (
    .idx(idx_q), .rd(rd_q), .dev(dev_q), .reg_addr(reg_q), .len(len_q), .wr_data(wdata_q),
    .word(gen_word), .is_last(is_last), .is_rd_data(is_rd_data)
  );
`ifdef I2C_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic to_q, to_d;
  assign tmo = (state_q == S_ARM || state_q == S_WAIT) && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
  always_comb begin
    cnt_d = state_q == S_ISSUE ? '0 : (state_q == S_ARM || state_q == S_WAIT) ? cnt_q + 1'b1 : cnt_q;
    to_d  = accept ? 1'b0 : to_q | tmo;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  assign err_timeout = state_q == S_DONE && to_q;
`else
  assign tmo         = 1'b0;
  assign err_timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= S_IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = accept ? S_ISSUE : S_IDLE;
      S_ISSUE:  state_d = S_ARM;
      // the engine loads on the strobe cycle, so busy is not meaningful yet
      S_ARM:    state_d = tmo ? S_DONE : S_WAIT;
      S_WAIT:   state_d = tmo ? S_DONE : byte_busy ? S_WAIT : S_RESULT;
      S_RESULT: state_d = is_last ? S_DONE : S_ISSUE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end
  always_comb begin
    rd_d       = accept ? cmd_rd : rd_q;
    dev_d      = accept ? cmd_dev_addr : dev_q;
    reg_d      = accept ? cmd_reg_addr : reg_q;
    len_d      = accept ? ((cmd_rd && len_c == '0) ? LEN_W'(1) : len_c) : len_q;
    wdata_d    = accept ? cmd_wr_data : wdata_q;
    idx_d      = accept ? '0 : (state_q == S_RESULT && !is_last) ? idx_q + 1'b1 : idx_q;
    word_d     = state_q == S_ISSUE ? gen_word : word_q;
    nack_d     = accept ? 1'b0 : nack_q | (state_q == S_RESULT && !is_rd_data && byte_read[8]);
    rd_valid_d = state_q == S_RESULT && is_rd_data;
    rd_data_d  = rd_valid_d ? byte_read[7:0] : rd_data_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rd_q       <= 1'b0;
      dev_q      <= '0;
      reg_q      <= '0;
      len_q      <= '0;
      wdata_q    <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      nack_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_q       <= rd_d;
      dev_q      <= dev_d;
      reg_q      <= reg_d;
      len_q      <= len_d;
      wdata_q    <= wdata_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      nack_q     <= nack_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  // the engine has no reset, so a fresh request waits for it to drain
  always_comb begin
    cmd_ready   = state_q == S_IDLE && !byte_busy;
    byte_strobe = state_q == S_ISSUE;
    byte_word   = state_q == S_ISSUE ? gen_word : word_q;
    done        = state_q == S_DONE;
    err_nack    = state_q == S_DONE && nack_q;
    rd_valid    = rd_valid_q;
    rd_data     = rd_data_q;
  end
endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// tb_i2c_txn_sequencer: directed self-checking bench with a simple byte-engine model
module tb_i2c_txn_sequencer;
  logic clk = 0, reset_n = 0, cmd_valid = 0, cmd_rd = 0, byte_busy = 0;
  logic [6:0] cmd_dev_addr = '0;
  logic [7:0] cmd_reg_addr = '0;
  logic [2:0] cmd_len = '0;
  logic [31:0] cmd_wr_data = '0;
  logic [8:0] byte_read = '0;
  logic cmd_ready, rd_valid, done, err_nack, err_timeout, byte_strobe;
  logic [7:0] rd_data;
  logic [15:0] byte_word;
  i2c_txn_sequencer #(.MAX_LEN(4), .LEN_W(3), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
    .cmd_dev_addr(cmd_dev_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_len(cmd_len), .cmd_wr_data(cmd_wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err_nack(err_nack), .err_timeout(err_timeout),
    .byte_strobe(byte_strobe), .byte_word(byte_word), .byte_read(byte_read), .byte_busy(byte_busy)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0, cyc = 0, ndone = 0, nf = 0, hold = 3, strobe_cyc = -1, acc_cyc = 0;
  logic model_en = 0, last_nack = 0, last_to = 0;
  logic [15:0] words[$];
  logic [7:0] rds[$];
  logic [8:0] resp[16];
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (rd_valid === 1'b1) rds.push_back(rd_data);
    if (done === 1'b1) begin
      ndone++;
      last_nack = err_nack;
      last_to = err_timeout;
    end
    if (byte_strobe === 1'b1) begin
      words.push_back(byte_word);
      if (strobe_cyc < 0) strobe_cyc = cyc;
    end
  end
  // engine model: busy from the cycle after the strobe for `hold` cycles, then returns resp[frame]
  initial forever begin
    @(negedge clk);
    if (model_en && byte_strobe === 1'b1) begin
      automatic int fr = nf;
      automatic logic [15:0] w = byte_word;
      nf++;
      @(posedge clk);
      #1 byte_busy = 1;
      repeat (hold) @(posedge clk);
      total++;
      if (byte_word !== w) begin bad++; $display("FAIL word_hold frame=%0d got=%h exp=%h", fr, byte_word, w); end
      #1 byte_read = resp[fr & 15];
      byte_busy = 0;
    end
  end
  task automatic run(input logic rd, input logic [6:0] dev, input logic [7:0] ra, input logic [2:0] len, input logic [31:0] wd);
    int g;
    words.delete(); rds.delete(); ndone = 0; nf = 0; strobe_cyc = -1;
    @(negedge clk);
    cmd_rd = rd; cmd_dev_addr = dev; cmd_reg_addr = ra; cmd_len = len; cmd_wr_data = wd; cmd_valid = 1;
    g = 0;
    while (cmd_ready !== 1'b1 && g < 100) begin @(negedge clk); g++; end
    acc_cyc = cyc;
    @(posedge clk);
    #1 cmd_valid = 0;
    total++;
    if (cmd_ready !== 1'b0) begin bad++; $display("FAIL ready_drop got=%b exp=0", cmd_ready); end
    g = 0;
    while (ndone == 0 && g < 500) begin @(negedge clk); g++; end
    repeat (3) @(negedge clk);
    total++;
    if (ndone != 1) begin bad++; $display("FAIL done_count got=%0d exp=1", ndone); end
  endtask
  task automatic test_reset();
    reset_n = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({done, byte_strobe, rd_valid, err_nack, err_timeout} !== 5'b0 || byte_word !== 16'h0 || rd_data !== 8'h0) begin
      bad++; $display("FAIL reset_outputs got=%b%b%b%b%b word=%h data=%h exp=0", done, byte_strobe, rd_valid, err_nack, err_timeout, byte_word, rd_data);
    end
    reset_n = 1;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
  endtask
  task automatic test_write();
    logic [15:0] e[3] = '{16'h813C, 16'h0102, 16'h4100};
    foreach (resp[i]) resp[i] = '0;
    run(1'b0, 7'h1E, 8'h02, 3'd1, 32'h0);
    total++; if (words.size() != 3) begin bad++; $display("FAIL write_nwords got=%0d exp=3", words.size()); end
    for (int i = 0; i < 3; i++) begin
      total++; if (words[i] !== e[i]) begin bad++; $display("FAIL write_word[%0d] got=%h exp=%h", i, words[i], e[i]); end
    end
    total++; if (strobe_cyc - acc_cyc != 1) begin bad++; $display("FAIL first_strobe_latency got=%0d exp=1", strobe_cyc - acc_cyc); end
    total++; if (last_nack !== 1'b0 || rds.size() != 0) begin bad++; $display("FAIL write_status nack=%b nrd=%0d exp nack=0 nrd=0", last_nack, rds.size()); end
  endtask
  task automatic test_read1();
    logic [15:0] e[4] = '{16'h81D0, 16'h0175, 16'h81D1, 16'h41FF};
    foreach (resp[i]) resp[i] = '0;
    resp[3] = 9'h068;
    run(1'b1, 7'h68, 8'h75, 3'd1, 32'h0);
    total++; if (words.size() != 4) begin bad++; $display("FAIL read1_nwords got=%0d exp=4", words.size()); end
    for (int i = 0; i < 4; i++) begin
      total++; if (words[i] !== e[i]) begin bad++; $display("FAIL read1_word[%0d] got=%h exp=%h", i, words[i], e[i]); end
    end
    total++; if (rds.size() != 1 || rds[0] !== 8'h68) begin bad++; $display("FAIL read1_data n=%0d got=%h exp n=1 68", rds.size(), rds[0]); end
  endtask
  task automatic test_read2();
    foreach (resp[i]) resp[i] = '0;
    resp[3] = 9'h112;
    resp[4] = 9'h134;
    run(1'b1, 7'h68, 8'h75, 3'd2, 32'h0);
    total++; if (words.size() != 5) begin bad++; $display("FAIL read2_nwords got=%0d exp=5", words.size()); end
    total++; if (words[3] !== 16'h00FF) begin bad++; $display("FAIL read2_word3 got=%h exp=00ff", words[3]); end
    total++; if (words[4] !== 16'h41FF) begin bad++; $display("FAIL read2_word4 got=%h exp=41ff", words[4]); end
    total++; if (rds.size() != 2 || rds[0] !== 8'h12 || rds[1] !== 8'h34) begin bad++; $display("FAIL read2_data n=%0d got=%h,%h exp=12,34", rds.size(), rds[0], rds[1]); end
    total++; if (last_nack !== 1'b0) begin bad++; $display("FAIL read2_nack got=%b exp=0", last_nack); end
  endtask
  task automatic test_nack();
    foreach (resp[i]) resp[i] = '0;
    resp[0] = 9'h100;
    run(1'b0, 7'h1E, 8'h02, 3'd0, 32'h0);
    total++; if (words.size() != 2 || words[1] !== 16'h4102) begin bad++; $display("FAIL nack_words n=%0d got=%h exp n=2 4102", words.size(), words[1]); end
    total++; if (last_nack !== 1'b1) begin bad++; $display("FAIL nack_flag got=%b exp=1", last_nack); end
  endtask
  task automatic test_clamp();
    logic [15:0] e[6] = '{16'h81A0, 16'h0110, 16'h0111, 16'h0122, 16'h0133, 16'h4144};
    foreach (resp[i]) resp[i] = '0;
    run(1'b0, 7'h50, 8'h10, 3'd7, 32'h44332211);
    total++; if (words.size() != 6) begin bad++; $display("FAIL clamp_nwords got=%0d exp=6", words.size()); end
    for (int i = 0; i < 6; i++) begin
      total++; if (words[i] !== e[i]) begin bad++; $display("FAIL clamp_word[%0d] got=%h exp=%h", i, words[i], e[i]); end
    end
    total++; if (last_nack !== 1'b0) begin bad++; $display("FAIL clamp_nack_cleared got=%b exp=0", last_nack); end
  endtask
  task automatic test_read_len0();
    foreach (resp[i]) resp[i] = '0;
    resp[3] = 9'h0AB;
    run(1'b1, 7'h68, 8'h75, 3'd0, 32'h0);
    total++; if (words.size() != 4 || words[3] !== 16'h41FF) begin bad++; $display("FAIL rdlen0_words n=%0d got=%h exp n=4 41ff", words.size(), words[3]); end
    total++; if (rds.size() != 1 || rds[0] !== 8'hAB) begin bad++; $display("FAIL rdlen0_data n=%0d got=%h exp n=1 ab", rds.size(), rds[0]); end
  endtask
  task automatic test_reset_mid_frame();
    int errs = 0;
    model_en = 0;
    @(negedge clk);
    byte_busy = 1;
    reset_n = 0;
    repeat (3) @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      total++;
      if (cmd_ready !== 1'b0 || byte_strobe !== 1'b0) begin bad++; errs++; if (errs < 4) $display("FAIL busy_hold cyc=%0d ready=%b strobe=%b exp 0 0", i, cmd_ready, byte_strobe); end
    end
    byte_busy = 0;
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL busy_release ready=%b exp=1", cmd_ready); end
    model_en = 1;
  endtask
`ifdef I2C_TIMEOUT_EN
  task automatic test_timeout();
    int g = 0;
    foreach (resp[i]) resp[i] = '0;
    hold = 400;
    run(1'b1, 7'h68, 8'h75, 3'd1, 32'h0);
    total++; if (last_to !== 1'b1) begin bad++; $display("FAIL timeout_flag got=%b exp=1", last_to); end
    total++; if (words.size() != 1 || rds.size() != 0) begin bad++; $display("FAIL timeout_frames strobes=%0d rd=%0d exp 1 0", words.size(), rds.size()); end
    while (byte_busy && g < 1000) begin @(negedge clk); g++; end
    hold = 3;
  endtask
`endif
  initial begin
    foreach (resp[i]) resp[i] = '0;
    test_reset();
    model_en = 1;
    test_write();
    test_read1();
    test_read2();
    test_nack();
    test_clamp();
    test_read_len0();
    test_reset_mid_frame();
`ifdef I2C_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
